// File: rtl/key_vault_pkg.sv
// Shared types and sizing helpers for the multi-slot key store.
// Holds the controller state encoding and the default parameter values.
package key_vault_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_COMMIT  = 2'd2,
    ST_ZEROIZE = 2'd3
  } state_e;

  localparam int DEF_KEY_LENGTH = 128;
  localparam int DEF_WORD_WIDTH = 32;
  localparam int DEF_NUM_SLOTS  = 4;

  function automatic int calc_num_words(input int key_length, input int word_width);
    return key_length / word_width;
  endfunction

  // Index width for a range of n entries, never narrower than one bit.
  function automatic int calc_index_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_vault_loader.sv
// Word-serial key assembler: staging register, word counter and word_ready.
// The controller says when a load starts, when staging must be wiped, and when LOAD is active.
module key_vault_loader
  import key_vault_pkg::*;
#(
  parameter int KEY_LENGTH = DEF_KEY_LENGTH,
  parameter int WORD_WIDTH = DEF_WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  clear,
  input  logic                  active,
  input  logic                  word_valid,
  input  logic [WORD_WIDTH-1:0] word_data,
  output logic                  word_ready,
  output logic                  last_xfer,
  output logic [KEY_LENGTH-1:0] staging
);

  localparam int NUM_WORDS = calc_num_words(KEY_LENGTH, WORD_WIDTH);
  localparam int CNT_W     = calc_index_w(NUM_WORDS);

  logic [KEY_LENGTH-1:0] staging_q, staging_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  xfer;

  assign word_ready = active;
  assign xfer       = active && word_valid;
  assign last_xfer  = xfer && (cnt_q == CNT_W'(NUM_WORDS - 1));
  assign staging    = staging_q;

  always_comb begin
    staging_d = staging_q;
    cnt_d     = cnt_q;
    // A wipe (zeroize or commit) wins over a word arriving in the same cycle.
    if (clear || start) begin
      staging_d = '0;
      cnt_d     = '0;
    end else if (xfer) begin
      for (int w = 0; w < NUM_WORDS; w++) begin
        if (cnt_q == CNT_W'(w)) begin
          staging_d[w*WORD_WIDTH +: WORD_WIDTH] = word_data;
        end
      end
      cnt_d = last_xfer ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      staging_q <= '0;
      cnt_q     <= '0;
    end else begin
      staging_q <= staging_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: rtl/key_vault.sv
// Multi-slot key store: load/lock/zeroize controller, per-slot key, valid and
// lock flags, and the registered read port feeding the decryption datapath.
module key_vault
  import key_vault_pkg::*;
#(
  parameter int  KEY_LENGTH = DEF_KEY_LENGTH,
  parameter int  WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int  NUM_SLOTS  = DEF_NUM_SLOTS,
  localparam int SLOT_W     = calc_index_w(NUM_SLOTS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_start,
  input  logic [SLOT_W-1:0]     load_slot,
  input  logic                  word_valid,
  input  logic [WORD_WIDTH-1:0] word_data,
  output logic                  word_ready,
  input  logic                  lock_req,
  input  logic [SLOT_W-1:0]     lock_slot,
  input  logic                  zeroize,
  input  logic [SLOT_W-1:0]     rd_slot,
  output logic [KEY_LENGTH-1:0] key_out,
  output logic                  key_valid,
  output logic                  busy,
  output logic                  err
);

  if (KEY_LENGTH % WORD_WIDTH != 0) begin : g_bad_key_length
    $error("key_vault: KEY_LENGTH must be a multiple of WORD_WIDTH");
  end

  state_e                                state_q, state_d;
  logic [NUM_SLOTS-1:0][KEY_LENGTH-1:0]  key_q, key_d;
  logic [NUM_SLOTS-1:0]                  valid_q, valid_d;
  logic [NUM_SLOTS-1:0]                  locked_q, locked_d;
  logic [SLOT_W-1:0]                     slot_q, slot_d;
  logic [SLOT_W-1:0]                     sweep_q, sweep_d;
  logic                                  err_q, err_d;
  logic [KEY_LENGTH-1:0]                 key_out_q, key_out_d;
  logic                                  key_valid_q, key_valid_d;

  logic                  ld_start;
  logic                  ld_clear;
  logic                  ld_active;
  logic                  last_xfer;
  logic [KEY_LENGTH-1:0] staging;

  // Slot selects go through loops so non-power-of-two slot counts never index past the arrays.
  function automatic logic in_range(input logic [SLOT_W-1:0] s);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (s == SLOT_W'(i)) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic sel_flag(input logic [NUM_SLOTS-1:0] flags,
                                    input logic [SLOT_W-1:0]    s);
    logic f;
    f = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (s == SLOT_W'(i)) f = flags[i];
    end
    return f;
  endfunction

  assign ld_active = (state_q == ST_LOAD);
  assign busy      = (state_q != ST_IDLE);
  assign err       = err_q;
  assign key_out   = key_out_q;
  assign key_valid = key_valid_q;

  key_vault_loader #(
    .KEY_LENGTH (KEY_LENGTH),
    .WORD_WIDTH (WORD_WIDTH)
  ) u_loader (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (ld_start),
    .clear      (ld_clear),
    .active     (ld_active),
    .word_valid (word_valid),
    .word_data  (word_data),
    .word_ready (word_ready),
    .last_xfer  (last_xfer),
    .staging    (staging)
  );

  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    valid_d  = valid_q;
    locked_d = locked_q;
    slot_d   = slot_q;
    sweep_d  = sweep_q;
    err_d    = 1'b0;
    ld_start = 1'b0;
    ld_clear = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (zeroize) begin
          state_d  = ST_ZEROIZE;
          sweep_d  = '0;
          ld_clear = 1'b1;
        end else if (lock_req) begin
          // A lock request shadows any load_start in the same cycle, accepted or not.
          if (in_range(lock_slot) && sel_flag(valid_q, lock_slot)) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
              if (lock_slot == SLOT_W'(i)) locked_d[i] = 1'b1;
            end
          end else begin
            err_d = 1'b1;
          end
        end else if (load_start) begin
          if (in_range(load_slot) && !sel_flag(locked_q, load_slot)) begin
            slot_d   = load_slot;
            ld_start = 1'b1;
            state_d  = ST_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (zeroize) begin
          state_d  = ST_ZEROIZE;
          sweep_d  = '0;
          ld_clear = 1'b1;
        end else if (last_xfer) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        ld_clear = 1'b1;
        if (zeroize) begin
          state_d = ST_ZEROIZE;
          sweep_d = '0;
        end else begin
          for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slot_q == SLOT_W'(i)) begin
              key_d[i]   = staging;
              valid_d[i] = 1'b1;
            end
          end
          state_d = ST_IDLE;
        end
      end
      ST_ZEROIZE: begin
        ld_clear = 1'b1;
        for (int i = 0; i < NUM_SLOTS; i++) begin
          if (sweep_q == SLOT_W'(i)) begin
            key_d[i]    = '0;
            valid_d[i]  = 1'b0;
            locked_d[i] = 1'b0;
          end
        end
        if (sweep_q == SLOT_W'(NUM_SLOTS - 1)) begin
          state_d = ST_IDLE;
          sweep_d = '0;
        end else begin
          sweep_d = sweep_q + SLOT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read port is blanked for the whole sweep so partially cleared slots never leak.
  always_comb begin
    key_out_d   = '0;
    key_valid_d = 1'b0;
    if (state_q != ST_ZEROIZE) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (rd_slot == SLOT_W'(i)) begin
          key_valid_d = valid_q[i];
          key_out_d   = valid_q[i] ? key_q[i] : '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      key_q       <= '0;
      valid_q     <= '0;
      locked_q    <= '0;
      slot_q      <= '0;
      sweep_q     <= '0;
      err_q       <= 1'b0;
      key_out_q   <= '0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      valid_q     <= valid_d;
      locked_q    <= locked_d;
      slot_q      <= slot_d;
      sweep_q     <= sweep_d;
      err_q       <= err_d;
      key_out_q   <= key_out_d;
      key_valid_q <= key_valid_d;
    end
  end

endmodule

// File: tb/tb_key_vault.sv
// Scoreboard bench for key_vault: stimulus pushes expected outputs, a monitor pops and compares.
// The reference model is a plain array of keys with valid/lock flags updated per operation.
module tb_key_vault;

  localparam int KL = 128;
  localparam int WW = 32;
  localparam int NS = 4;
  localparam int SW = 2;
  localparam int NW = KL / WW;

  localparam int K_KEY  = 0;
  localparam int K_KV   = 1;
  localparam int K_ERR  = 2;
  localparam int K_BUSY = 3;
  localparam int K_WR   = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_start;
  logic [SW-1:0] load_slot;
  logic          word_valid;
  logic [WW-1:0] word_data;
  logic          word_ready;
  logic          lock_req;
  logic [SW-1:0] lock_slot;
  logic          zeroize;
  logic [SW-1:0] rd_slot;
  logic [KL-1:0] key_out;
  logic          key_valid;
  logic          busy;
  logic          err;

  always #5 clk = ~clk;

  key_vault #(
    .KEY_LENGTH (KL),
    .WORD_WIDTH (WW),
    .NUM_SLOTS  (NS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .load_slot  (load_slot),
    .word_valid (word_valid),
    .word_data  (word_data),
    .word_ready (word_ready),
    .lock_req   (lock_req),
    .lock_slot  (lock_slot),
    .zeroize    (zeroize),
    .rd_slot    (rd_slot),
    .key_out    (key_out),
    .key_valid  (key_valid),
    .busy       (busy),
    .err        (err)
  );

  typedef struct {
    int            due;
    int            kind;
    logic [KL-1:0] val;
  } exp_t;

  exp_t          sb[$];
  int            cyc = 0;
  int            vectors = 0;
  int            miscompares = 0;

  logic [KL-1:0] m_key    [NS];
  bit            m_valid  [NS];
  bit            m_locked [NS];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input int kind, input logic [KL-1:0] expv);
    logic [KL-1:0] act;
    string         nm;
    case (kind)
      K_KEY:   begin act = key_out;    nm = "key_out";    end
      K_KV:    begin act = KL'(key_valid);  nm = "key_valid";  end
      K_ERR:   begin act = KL'(err);        nm = "err";        end
      K_BUSY:  begin act = KL'(busy);       nm = "busy";       end
      default: begin act = KL'(word_ready); nm = "word_ready"; end
    endcase
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, expv);
    end
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      check(e.kind, e.val);
    end
  end

  task automatic push(input int kind, input logic [KL-1:0] v);
    sb.push_back('{due: cyc + 1, kind: kind, val: v});
  endtask

  // Expectations describe outputs after the coming rising edge.
  task automatic step(input bit e_err, input bit e_busy, input bit e_wr);
    push(K_ERR, KL'(e_err));
    push(K_BUSY, KL'(e_busy));
    push(K_WR, KL'(e_wr));
    @(negedge clk);
  endtask

  function automatic void model_clear();
    for (int i = 0; i < NS; i++) begin
      m_key[i]    = '0;
      m_valid[i]  = 1'b0;
      m_locked[i] = 1'b0;
    end
  endfunction

  function automatic logic [KL-1:0] rk();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic do_read(input int s);
    rd_slot = SW'(s);
    push(K_KEY, m_valid[s] ? m_key[s] : '0);
    push(K_KV, KL'(m_valid[s]));
    step(1'b0, 1'b0, 1'b0);
  endtask

  // NS-cycle sweep following the zeroize edge; read port must stay blank throughout.
  task automatic sweep();
    for (int i = 0; i < NS; i++) begin
      zeroize = (i == 1);
      push(K_KEY, '0);
      push(K_KV, '0);
      step(1'b0, i != NS - 1, 1'b0);
    end
    zeroize = 1'b0;
    model_clear();
  endtask

  task automatic do_zeroize_idle();
    zeroize = 1'b1;
    step(1'b0, 1'b1, 1'b0);
    zeroize = 1'b0;
    sweep();
  endtask

  // gap < 0 picks 0..2 idle cycles per word; abort_after < NW zeroizes before that word.
  task automatic do_load(input int s, input logic [KL-1:0] key, input int gap, input int abort_after);
    bit accept;
    int g;
    accept     = !m_locked[s];
    load_start = 1'b1;
    load_slot  = SW'(s);
    step(!accept, accept, accept);
    load_start = 1'b0;
    if (!accept) return;
    for (int i = 0; i < NW; i++) begin
      if (i == abort_after) begin
        zeroize = 1'b1;
        step(1'b0, 1'b1, 1'b0);
        zeroize = 1'b0;
        sweep();
        return;
      end
      g = (gap < 0) ? $urandom_range(0, 2) : gap;
      repeat (g) begin
        word_valid = 1'b0;
        word_data  = $urandom();
        step(1'b0, 1'b1, 1'b1);
      end
      word_valid = 1'b1;
      word_data  = key[i*WW +: WW];
      step(1'b0, 1'b1, i != NW - 1);
      word_valid = 1'b0;
    end
    step(1'b0, 1'b0, 1'b0);
    m_key[s]   = key;
    m_valid[s] = 1'b1;
  endtask

  task automatic do_lock(input int s);
    bit ok;
    ok       = m_valid[s];
    lock_req = 1'b1;
    lock_slot = SW'(s);
    step(!ok, 1'b0, 1'b0);
    lock_req = 1'b0;
    if (ok) m_locked[s] = 1'b1;
  endtask

  // Lock and load in the same idle cycle: the load is always dropped.
  task automatic do_lock_load(input int ls, input int ds);
    bit ok;
    ok         = m_valid[ls];
    lock_req   = 1'b1;
    lock_slot  = SW'(ls);
    load_start = 1'b1;
    load_slot  = SW'(ds);
    step(!ok, 1'b0, 1'b0);
    lock_req   = 1'b0;
    load_start = 1'b0;
    if (ok) m_locked[ls] = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by time limit, expected finish");
    $fatal(1);
  end

  initial begin
    logic [KL-1:0] k1;
    int op;
    rst_n = 1'b0; load_start = 1'b0; load_slot = '0; word_valid = 1'b0; word_data = '0;
    lock_req = 1'b0; lock_slot = '0; zeroize = 1'b0; rd_slot = '0;
    model_clear();
    repeat (3) @(negedge clk);
    check(K_KEY, '0); check(K_KV, '0); check(K_BUSY, '0); check(K_WR, '0); check(K_ERR, '0);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    do_read(0);

    k1 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    do_load(2, k1, 0, NW);
    do_read(2);

    do_lock(2);
    do_load(2, rk(), 0, NW);
    step(1'b0, 1'b0, 1'b0);
    do_read(2);
    do_lock(0);
    step(1'b0, 1'b0, 1'b0);

    do_load(1, rk(), 0, 2);
    do_read(2);
    do_read(1);
    do_load(2, rk(), 0, NW);
    do_read(2);

    do_lock_load(2, 2);
    do_load(2, rk(), 0, NW);
    step(1'b0, 1'b0, 1'b0);

    do_load(3, k1, 3, NW);
    do_read(3);

    for (int n = 0; n < 80; n++) begin
      op = $urandom_range(0, 11);
      if (op <= 3)       do_load($urandom_range(0, NS - 1), rk(), -1, NW);
      else if (op <= 5)  do_lock($urandom_range(0, NS - 1));
      else if (op <= 8)  do_read($urandom_range(0, NS - 1));
      else if (op == 9)  do_lock_load($urandom_range(0, NS - 1), $urandom_range(0, NS - 1));
      else if (op == 10) do_load($urandom_range(0, NS - 1), rk(), -1, $urandom_range(0, NW - 1));
      else               do_zeroize_idle();
    end

    do_zeroize_idle();
    do_load(0, rk(), 0, NW);
    do_read(0);
    load_start = 1'b1;
    load_slot  = SW'(1);
    step(1'b0, 1'b1, 1'b1);
    load_start = 1'b0;
    repeat (2) begin
      word_valid = 1'b1;
      word_data  = $urandom();
      step(1'b0, 1'b1, 1'b1);
    end
    #2 rst_n = 1'b0;
    #1;
    check(K_KEY, '0); check(K_KV, '0); check(K_BUSY, '0); check(K_WR, '0); check(K_ERR, '0);
    model_clear();
    word_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    do_read(0);
    do_load(1, rk(), 0, NW);
    do_read(1);

    repeat (2) @(negedge clk);
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
